// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder : registered ripple-carry adder of WIDTH bits (1..64).
// A ripple chain of 1-bit full-adder cells computes {carry,sum} = a + b + cin.
// A qualified input (in_valid=1) is captured on the next rising clk edge and
// out_valid marks it for one cycle. When in_valid=0 the result is held and
// out_valid drops.
// rst_n clears the outputs asynchronously. Reset release is re-timed through
// one flop, so capture is enabled starting with the clk edge that follows the
// edge at which rst_n is first sampled high.
// Optional feature macro: FULL_ADDER_OVF_EN adds the ovf output (two's-
// complement overflow), which is registered alongside sum.
// -----------------------------------------------------------------------------
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef FULL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // ripple chain: w_c[i] is the carry into cell i, and w_c[WIDTH] is the carry-out
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_s;
   logic             w_load;

   logic             r_rst_sync;
   logic             r_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;

   assign w_c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   // capture only once the re-timed reset release has reached the core
   assign w_load = in_valid & r_rst_sync;

   // reset release re-timing: assert asynchronously, release on the first sampled-high edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_sync <= 1'b1;
      end
   end

   // result registers: load on a qualified input, otherwise hold; valid is a one-cycle mark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_sum   <= {WIDTH{1'b0}};
         r_carry <= 1'b0;
      end else begin
         r_valid <= w_load;
         if (w_load) begin
            r_sum   <= w_s;
            r_carry <= w_c[WIDTH];
         end else begin
            r_sum   <= r_sum;
            r_carry <= r_carry;
         end
      end
   end

   assign out_valid = r_valid;
   assign sum       = r_sum;
   assign carry     = r_carry;

`ifdef FULL_ADDER_OVF_EN
   // overflow: the operands share a sign bit and the result's sign bit differs from it
   logic w_ovf;
   logic r_ovf;

   assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_s[WIDTH-1] != a[WIDTH-1]);

   // overflow register follows the same load/hold/reset rules as carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else begin
         if (w_load) begin
            r_ovf <= w_ovf;
         end else begin
            r_ovf <= r_ovf;
         end
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder : self-checking bench for full_adder at WIDTH = 1, 4 and 64.
// The reference is plain integer arithmetic: a + b + cin, with overflow taken
// as the signed result falling outside the representable range.
// -----------------------------------------------------------------------------
module tb_full_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec;
   int   n_err;

   always #5 clk = ~clk;

   // WIDTH = 1 instance
   logic       iv1, a1, b1, cin1, ov1, s1, c1;
   // WIDTH = 4 instance
   logic       iv4, cin4, ov4, c4;
   logic [3:0] a4, b4, s4;
   // WIDTH = 64 instance
   logic        iv64, cin64, ov64, c64;
   logic [63:0] a64, b64, s64;
`ifdef FULL_ADDER_OVF_EN
   logic       f1, f4, f64;
`endif

   full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
      .out_valid(ov1), .sum(s1), .carry(c1)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(f1)
`endif
   );

   full_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ov4), .sum(s4), .carry(c4)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(f4)
`endif
   );

   full_adder #(.WIDTH(64)) u_w64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .a(a64), .b(b64), .cin(cin64),
      .out_valid(ov64), .sum(s64), .carry(c64)
`ifdef FULL_ADDER_OVF_EN
      , .ovf(f64)
`endif
   );

   // advance one clk edge and step off it before sampling or driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference for the 4-bit instance: unsigned {carry,sum} and signed overflow
   function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
      int tot, sa, sb, ss;
      logic ovf;
      tot = int'(a) + int'(b) + int'(c);
      sa  = (a >= 4'd8) ? int'(a) - 16 : int'(a);
      sb  = (b >= 4'd8) ? int'(b) - 16 : int'(b);
      ss  = sa + sb + int'(c);
      ovf = (ss > 7) || (ss < -8);
      return {ovf, tot[4], tot[3:0]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
      iv64 = 1'b1; a64 = '1; b64 = '1; cin64 = 1'b1;
      #2;
      step();
      step();
      n_vec++;
      if ({ov1, c1, s1} !== 3'b000 || {ov4, c4, s4} !== 6'b0 || {ov64, c64, s64} !== 66'b0) begin
         n_err++;
         $display("FAIL reset_state: w1=%b w4=%b w64_v=%b c=%b s=%h, required all zero",
                  {ov1, c1, s1}, {ov4, c4, s4}, ov64, c64, s64);
      end
      // release; the next edge only samples rst_n high, and capture starts on the edge after
      rst_n = 1'b1;
      step();
      n_vec++;
      if (ov1 !== 1'b0 || ov4 !== 1'b0 || ov64 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_sync: out_valid w1/w4/w64=%b%b%b, required 000", ov1, ov4, ov64);
      end
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b1_1_1111) begin
         n_err++;
         $display("FAIL reset_first_capture: {v,c,s}=%b, required 111111", {ov4, c4, s4});
      end
   endtask

   task automatic test_w1_exhaustive();
      int tot;
      for (int i = 0; i < 8; i++) begin
         iv1 = 1'b1; a1 = i[2]; b1 = i[1]; cin1 = i[0];
         tot = i[2] + i[1] + i[0];
         step();
         n_vec++;
         if ({ov1, c1, s1} !== {1'b1, tot >= 2, tot[0]}) begin
            n_err++;
            $display("FAIL w1_truth a=%b b=%b cin=%b: {v,c,s}=%b, required %b%b%b",
                     a1, b1, cin1, {ov1, c1, s1}, 1'b1, tot >= 2, tot[0]);
         end
      end
      iv1 = 1'b0;
   endtask

   task automatic test_w4_directed();
      logic [5:0] exp;
      iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b1_1_0000) begin
         n_err++;
         $display("FAIL w4_F_plus_1: {v,c,s}=%b, required 110000", {ov4, c4, s4});
      end
      // idle cycles with changing inputs: result held, out_valid low
      iv4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
         step();
         n_vec++;
         if ({ov4, c4, s4} !== 6'b0_1_0000) begin
            n_err++;
            $display("FAIL w4_idle_hold %0d: {v,c,s}=%b, required 010000", k, {ov4, c4, s4});
         end
      end
      iv4 = 1'b1; a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
      exp = ref4(a4, b4, cin4);
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b1_0_1000) begin
         n_err++;
         $display("FAIL w4_7_plus_1: {v,c,s}=%b, required 101000", {ov4, c4, s4});
      end
`ifdef FULL_ADDER_OVF_EN
      n_vec++;
      if (f4 !== exp[5] || f4 !== 1'b1) begin
         n_err++;
         $display("FAIL w4_ovf_7_plus_1: ovf=%b, required 1", f4);
      end
`endif
      a4 = 4'h8; b4 = 4'h8; cin4 = 1'b0;
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b1_1_0000) begin
         n_err++;
         $display("FAIL w4_8_plus_8: {v,c,s}=%b, required 110000", {ov4, c4, s4});
      end
`ifdef FULL_ADDER_OVF_EN
      n_vec++;
      if (f4 !== 1'b1) begin
         n_err++;
         $display("FAIL w4_ovf_8_plus_8: ovf=%b, required 1", f4);
      end
      iv4 = 1'b0; a4 = 4'h1; b4 = 4'h1;
      step();
      n_vec++;
      if (f4 !== 1'b1 || ov4 !== 1'b0) begin
         n_err++;
         $display("FAIL w4_ovf_hold: ovf=%b v=%b, required ovf=1 v=0", f4, ov4);
      end
`endif
      iv4 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [5:0]  exp4;
      logic [64:0] exp64;
      iv4 = 1'b1; iv64 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
         a64 = {32'($urandom), 32'($urandom)};
         b64 = {32'($urandom), 32'($urandom)};
         cin64 = 1'($urandom);
         if (k == 10) begin
            a64 = '1; b64 = '1; cin64 = 1'b1;
         end
         if (k == 11) begin
            a64 = '1; b64 = 64'd0; cin64 = 1'b1;
         end
         exp4  = ref4(a4, b4, cin4);
         exp64 = {1'b0, a64} + {1'b0, b64} + {64'd0, cin64};
         step();
         n_vec++;
         if ({ov4, c4, s4} !== {1'b1, exp4[4:0]}) begin
            n_err++;
            $display("FAIL stream_w4 %0d: {v,c,s}=%b, required %b", k, {ov4, c4, s4}, {1'b1, exp4[4:0]});
         end
`ifdef FULL_ADDER_OVF_EN
         if (f4 !== exp4[5]) begin
            n_err++;
            $display("FAIL stream_w4_ovf %0d: ovf=%b, required %b", k, f4, exp4[5]);
         end
`endif
         n_vec++;
         if (ov64 !== 1'b1 || {c64, s64} !== exp64) begin
            n_err++;
            $display("FAIL stream_w64 %0d: v=%b {c,s}=%h, required v=1 %h", k, ov64, {c64, s64}, exp64);
         end
      end
      iv4 = 1'b0; iv64 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp4;
      iv4 = 1'b1; a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b1_1_0011) begin
         n_err++;
         $display("FAIL mid_pre_reset: {v,c,s}=%b, required 110011", {ov4, c4, s4});
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ov4, c4, s4} !== 6'b0 || {ov64, c64, s64} !== 66'b0) begin
         n_err++;
         $display("FAIL mid_reset_immediate: w4=%b w64_v=%b, required zeros", {ov4, c4, s4}, ov64);
      end
`ifdef FULL_ADDER_OVF_EN
      if (f4 !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_ovf: ovf=%b, required 0", f4);
      end
`endif
      step();
      rst_n = 1'b1;
      iv4 = 1'b0;
      step();
      n_vec++;
      if ({ov4, c4, s4} !== 6'b0) begin
         n_err++;
         $display("FAIL mid_after_release: {v,c,s}=%b, required 000000", {ov4, c4, s4});
      end
      iv4 = 1'b1; a4 = 4'h5; b4 = 4'hC; cin4 = 1'b0;
      exp4 = ref4(a4, b4, cin4);
      step();
      n_vec++;
      if ({ov4, c4, s4} !== {1'b1, exp4[4:0]}) begin
         n_err++;
         $display("FAIL mid_first_result: {v,c,s}=%b, required %b", {ov4, c4, s4}, {1'b1, exp4[4:0]});
      end
      iv4 = 1'b0;
      step();
      n_vec++;
      if (ov4 !== 1'b0) begin
         n_err++;
         $display("FAIL mid_valid_drop: v=%b, required 0", ov4);
      end
   endtask

   // top-level sequence of all scenarios
   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_w1_exhaustive();
      test_w4_directed();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the operand width in bits (legal range 1..64).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit, qualifying a, b and cin in the current cycle.
REQ-005 The module SHALL have port a, input, WIDTH bits, unsigned addend.
REQ-006 The module SHALL have port b, input, WIDTH bits, unsigned addend.
REQ-007 The module SHALL have port cin, input, 1 bit, carry-in.
REQ-008 The module SHALL have port out_valid, output, 1 bit, marking sum and carry as a fresh result.
REQ-009 The module SHALL have port sum, output, WIDTH bits, registered sum bits.
REQ-010 The module SHALL have port carry, output, 1 bit, registered carry-out of the MSB.

Function
REQ-011 The adder SHALL be built as a ripple chain of 1-bit full-adder cells: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = cin.
REQ-012 {carry,sum} SHALL equal a + b + cin, computed modulo 2^(WIDTH+1), with no truncation of the carry-out.
REQ-013 Latency SHALL be exactly 1 cycle: a clk edge with in_valid=1 loads sum/carry and sets out_valid=1 after that edge.
REQ-014 A clk edge with in_valid=0 SHALL clear out_valid to 0 and hold sum and carry at their previous values.
REQ-015 Back-to-back in_valid=1 cycles SHALL produce one result per cycle, with no stall and no backpressure input.
REQ-016 Input values present while in_valid=0 SHALL NOT affect any output.
REQ-017 When WIDTH=1 the block SHALL behave as a registered classic full adder (sum = a^b^cin; carry = majority(a,b,cin)).

Reset
REQ-018 rst_n low SHALL immediately, without waiting for clk, force sum=0, carry=0, out_valid=0 (and ovf=0 when present).
REQ-019 Reset deassertion SHALL be synchronised internally; the first capture SHALL occur on the first clk edge after rst_n is sampled high.
REQ-020 rst_n asserting in the cycle after an in_valid=1 edge SHALL discard that result, and out_valid SHALL NOT pulse.

Configuration
REQ-021 With macro FULL_ADDER_OVF_EN defined, the module SHALL add output port ovf, 1 bit, registered with sum: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), i.e. two's-complement overflow.
REQ-022 ovf SHALL follow the same load, hold and reset rules as carry.
REQ-023 Without FULL_ADDER_OVF_EN, port ovf and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-024 WIDTH=1, exhaustive: all 8 {a,b,cin} combinations with in_valid=1 -> one cycle later, sum/carry match the truth table (e.g. 1,1,1 -> sum=1, carry=1; 1,0,0 -> sum=1, carry=0).
REQ-025 WIDTH=4: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, carry=1, out_valid=1 next cycle; then in_valid=0 -> out_valid=0, sum/carry held.
REQ-026 WIDTH=4, FULL_ADDER_OVF_EN defined: a=4'h7, b=4'h1, cin=0 -> sum=4'h8, carry=0, ovf=1; a=4'h8, b=4'h8 -> sum=0, carry=1, ovf=1.
REQ-027 Streaming: 10 consecutive random in_valid=1 vectors -> 10 consecutive out_valid=1 results, each equal to a+b+cin of the vector one cycle earlier.
REQ-028 Reset mid-operation: drive rst_n low between clk edges while out_valid=1 -> sum, carry and out_valid become 0 immediately; the first result after release appears one cycle after the first post-reset in_valid=1.
